// File: rtl/eth_tx_scheduler.sv
// Transmit-request scheduler: latched per-source requests with hold-off, round-robin grant,
// tx-busy tracking and inter-frame gap. Define ETH_TX_SCHED_FIXED_PRIO_EN for lowest-index-wins priority.
module eth_tx_scheduler #(
  parameter int NUM_SOURCES    = 2,
  parameter int HOLDOFF_CYCLES = 100,
  parameter int IFG_CYCLES     = 48,
  parameter int START_TIMEOUT  = 64,
  localparam int SEL_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_SOURCES-1:0] req_in,
  input  logic                   tx_busy_in,
  output logic                   transmit_out,
  output logic [SEL_W-1:0]       sel_out,
  output logic [NUM_SOURCES-1:0] grant_out,
  output logic [NUM_SOURCES-1:0] pending_out,
  output logic [15:0]            drop_count_out,
  output logic                   err_timeout_out
);
  // state      | meaning
  // S_IDLE     | waiting for an eligible source; foreign tx activity diverts to S_BUSY
  // S_LAUNCH   | one-cycle transmit pulse and grant for source sel
  // S_WAIT     | waiting for tx busy to rise, bounded by START_TIMEOUT
  // S_BUSY     | frame on the wire, waiting for tx busy to fall
  // S_GAP      | inter-frame gap countdown, no launch possible
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_BUSY   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam int HW   = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam int TMAX = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  logic [2:0]             state;
  logic [SEL_W-1:0]       sel;
  logic [TW-1:0]          cnt;
  logic                   err;
  logic [NUM_SOURCES-1:0] pending;
  logic [HW-1:0]          holdoff [NUM_SOURCES];
  logic [15:0]            drop_count;
  logic [SEL_W-1:0]       ptr;

  logic [NUM_SOURCES-1:0]   eligible, sel_hot, clr, set, drop;
  logic [2*NUM_SOURCES-1:0] rot;
  logic [3:0]               drop_sum;
  logic [16:0]              drop_ext;
  logic                     pick_valid;
  logic [SEL_W-1:0]         pick;
  int                       pick_idx;

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      eligible[i] = pending[i] && (holdoff[i] == '0);
      sel_hot[i]  = (sel == SEL_W'(i));
    end
  end

  // A request coinciding with its own launch re-pends the slot instead of dropping.
  assign clr = (state == S_LAUNCH) ? sel_hot : '0;
  assign set  = req_in & ~(pending & ~clr);
  assign drop = req_in & pending & ~clr;

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_SOURCES; i++) drop_sum = drop_sum + {3'b000, drop[i]};
  end
  assign drop_ext = {1'b0, drop_count} + {13'd0, drop_sum};

  // Search the eligibility vector rotated so that bit 0 is the pointer position.
  always_comb begin
    rot        = {eligible, eligible} >> ptr;
    pick_valid = 1'b0;
    pick       = '0;
    pick_idx   = 0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!pick_valid && rot[i]) begin
        pick_valid = 1'b1;
        pick_idx   = int'(ptr) + i;
        if (pick_idx >= NUM_SOURCES) pick_idx = pick_idx - NUM_SOURCES;
        pick       = SEL_W'(pick_idx);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending    <= '0;
      drop_count <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) holdoff[i] <= '0;
    end else begin
      drop_count <= drop_ext[16] ? 16'hFFFF : drop_ext[15:0];
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (set[i]) begin
          pending[i] <= 1'b1;
          holdoff[i] <= HW'(HOLDOFF_CYCLES);
        end else begin
          if (clr[i]) pending[i] <= 1'b0;
          if (holdoff[i] != '0) holdoff[i] <= holdoff[i] - 1'b1;
        end
      end
    end
  end

`ifdef ETH_TX_SCHED_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ptr <= '0;
    else if (state == S_LAUNCH) ptr <= (sel == SEL_W'(NUM_SOURCES - 1)) ? '0 : sel + 1'b1;
  end
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      sel   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_busy_in) state <= S_BUSY;
          else if (pick_valid) begin
            sel   <= pick;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= TW'(START_TIMEOUT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_busy_in) state <= S_BUSY;
          else if (cnt <= TW'(1)) begin
            err   <= 1'b1;
            cnt   <= TW'(IFG_CYCLES);
            state <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
          end else cnt <= cnt - 1'b1;
        end
        S_BUSY: begin
          if (!tx_busy_in) begin
            cnt   <= TW'(IFG_CYCLES);
            state <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (cnt <= TW'(1)) state <= S_IDLE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign transmit_out    = (state == S_LAUNCH);
  assign grant_out       = clr;
  assign sel_out         = sel;
  assign pending_out     = pending;
  assign drop_count_out  = drop_count;
  assign err_timeout_out = err;
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Bench for eth_tx_scheduler: timestamp-based reference model checked every cycle, plus directed scenarios.
module tb_eth_tx_scheduler;
  localparam int N  = 2;
  localparam int H  = 4;
  localparam int IFG = 8;
  localparam int TO = 16;
  localparam int BL = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic        foreign = 1'b0;
  logic        eng_busy = 1'b0;
  logic        tx_busy;
  logic        transmit;
  logic [0:0]  sel;
  logic [1:0]  grant, pending;
  logic [15:0] drops;
  logic        err;

  assign tx_busy = foreign | eng_busy;

  eth_tx_scheduler #(.NUM_SOURCES(N), .HOLDOFF_CYCLES(H), .IFG_CYCLES(IFG), .START_TIMEOUT(TO)) dut (
    .clk_in(clk), .rst_in(rst), .req_in(req), .tx_busy_in(tx_busy),
    .transmit_out(transmit), .sel_out(sel), .grant_out(grant), .pending_out(pending),
    .drop_count_out(drops), .err_timeout_out(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Simple tx engine: busy for BL cycles starting the cycle after a launch pulse.
  int eng_left = 0;
  bit eng_on = 1'b1;
  always @(negedge clk) begin
    if (rst) eng_left = 0;
    else if (transmit && eng_on) eng_left = BL;
  end
  always @(posedge clk) begin
    #1;
    if (!rst && eng_left > 0) begin
      eng_busy = 1'b1;
      eng_left--;
    end else eng_busy = 1'b0;
  end

  // Reference model: eligibility and scheduler availability as absolute cycle numbers.
  bit m_pend [N];
  int m_ready [N];
  int m_drops, m_sel, m_k, m_ptr, m_free_at, m_wait_until;
  bit m_err, m_launch, m_waiting, m_in_frame;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ready[i] = 0; end
    m_drops = 0; m_sel = 0; m_k = 0; m_ptr = 0; m_free_at = 0; m_wait_until = 0;
    m_err = 0; m_launch = 0; m_waiting = 0; m_in_frame = 0;
  endtask

  task automatic model_step(input int c);
    bit nl = 0;
    int nk = 0;
    int base;
`ifdef ETH_TX_SCHED_FIXED_PRIO_EN
    base = 0;
`else
    base = m_ptr;
`endif
    if (m_launch) begin
      m_waiting = 1; m_wait_until = c + TO; m_ptr = (m_k + 1) % N;
    end else if (m_waiting) begin
      if (tx_busy) begin m_waiting = 0; m_in_frame = 1; end
      else if (c == m_wait_until) begin m_waiting = 0; m_err = 1; m_free_at = c + 1 + IFG; end
    end else if (m_in_frame) begin
      if (!tx_busy) begin m_in_frame = 0; m_free_at = c + 1 + IFG; end
    end else if (c >= m_free_at) begin
      if (tx_busy) m_in_frame = 1;
      else
        for (int j = 0; j < N; j++) begin
          int idx = (base + j) % N;
          if (!nl && m_pend[idx] && c >= m_ready[idx]) begin nl = 1; nk = idx; end
        end
    end
    for (int i = 0; i < N; i++) begin
      bit clr = m_launch && (m_k == i);
      if (req[i]) begin
        if (m_pend[i] && !clr) begin if (m_drops < 65535) m_drops++; end
        else begin m_pend[i] = 1; m_ready[i] = c + 1 + H; end
      end else if (clr) m_pend[i] = 0;
    end
    m_launch = nl;
    if (nl) begin m_k = nk; m_sel = nk; end
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    else begin
      chk("transmit", {31'd0, transmit}, {31'd0, m_launch});
      chk("grant", {30'd0, grant}, m_launch ? (32'd1 << m_k) : 32'd0);
      chk("sel", {31'd0, sel}, m_sel);
      chk("pending", {30'd0, pending}, {30'd0, m_pend[1], m_pend[0]});
      chk("drop_count", {16'd0, drops}, m_drops);
      chk("err_timeout", {31'd0, err}, {31'd0, m_err});
      model_step(cyc);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; req = '0; foreign = 0; eng_on = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic pulse(input logic [1:0] m, output int c);
    @(posedge clk); #1;
    req = m; c = cyc;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic wait_tx(input string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (transmit) begin at = cyc; break; end
    end
    if (at < 0) chk({name, "_no_launch"}, 0, 1);
  endtask

  int c0, l1, l2, l3, b, e, n, dummy;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_transmit", {31'd0, transmit}, 0);
    chk("rst_pending", {30'd0, pending}, 0);
    chk("rst_drops", {16'd0, drops}, 0);
    chk("rst_err", {31'd0, err}, 0);

    // single request, hold-off latency
    pulse(2'b01, c0);
    wait_tx("t1", l1);
    chk("t1_latency", l1 - c0, 6);
    chk("t1_grant", {30'd0, grant}, 2'b01);
    chk("t1_sel", {31'd0, sel}, 0);
    repeat (40) @(posedge clk);

    // simultaneous requests, order and spacing
    do_reset();
    pulse(2'b11, c0);
    wait_tx("t2a", l1);
    chk("t2_grant1", {30'd0, grant}, 2'b01);
    pulse(2'b11, dummy);
    wait_tx("t2b", l2);
    chk("t2_spacing", l2 - l1, BL + IFG + 3);
`ifdef ETH_TX_SCHED_FIXED_PRIO_EN
    chk("t2_grant2", {30'd0, grant}, 2'b01);
`else
    chk("t2_grant2", {30'd0, grant}, 2'b10);
`endif
    wait_tx("t2c", l3);
    chk("t2_spacing3", l3 - l2, BL + IFG + 3);
`ifdef ETH_TX_SCHED_FIXED_PRIO_EN
    chk("t2_grant3", {30'd0, grant}, 2'b10);
`else
    chk("t2_grant3", {30'd0, grant}, 2'b01);
`endif
    repeat (40) @(posedge clk);

    // drops while pending, foreign busy blocks launch then full gap
    do_reset();
    @(posedge clk); #1 foreign = 1;
    pulse(2'b10, dummy);
    for (int i = 0; i < 3; i++) pulse(2'b10, dummy);
    @(negedge clk);
    chk("t3_drops", {16'd0, drops}, 3);
    @(posedge clk); #1 foreign = 0; b = cyc;
    wait_tx("t3", l1);
    chk("t3_after_foreign", l1 - b, IFG + 2);
    chk("t3_grant", {30'd0, grant}, 2'b10);
    repeat (40) @(posedge clk);

    // drop counter saturation
    do_reset();
    @(posedge clk); #1 foreign = 1; req = 2'b11;
    repeat (32768) @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    chk("t4_drops_fffe", {16'd0, drops}, 32'hFFFE);
    for (int i = 0; i < 3; i++) pulse(2'b10, dummy);
    @(negedge clk);
    chk("t4_drops_sat", {16'd0, drops}, 32'hFFFF);

    // start timeout
    do_reset();
    eng_on = 0;
    pulse(2'b01, c0);
    wait_tx("t5a", l1);
    e = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err) begin e = cyc; break; end
    end
    chk("t5_err_cycle", e - l1, TO + 1);
    eng_on = 1;
    pulse(2'b01, dummy);
    wait_tx("t5b", l2);
    chk("t5_grant_after", {30'd0, grant}, 2'b01);
    chk("t5_err_sticky", {31'd0, err}, 1);
    repeat (40) @(posedge clk);

    // request coinciding with its own launch
    do_reset();
    pulse(2'b01, c0);
    repeat (4) @(posedge clk);
    @(posedge clk); #1 req = 2'b01;
    @(negedge clk);
    chk("t6_launch_now", {31'd0, transmit}, 1);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("t6_repended", {31'd0, pending[0]}, 1);
    chk("t6_no_drop", {16'd0, drops}, 0);
    wait_tx("t6", l2);
    chk("t6_second", l2 - (c0 + 6), BL + IFG + 3);
    repeat (40) @(posedge clk);

    // asynchronous reset mid-frame
    do_reset();
    pulse(2'b11, c0);
    wait_tx("t7", l1);
    pulse(2'b01, dummy);
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("t7_rst_pending", {30'd0, pending}, 0);
    chk("t7_rst_transmit", {31'd0, transmit}, 0);
    chk("t7_rst_drops", {16'd0, drops}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (transmit) n++;
    end
    chk("t7_no_launch", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Parametrised transmit-request scheduler between N frame-request sources (button edge, RX echo trigger, future protocol engines) and the single RMII eth_tx engine.
- Replaces the ad-hoc OR of transmit triggers and the fixed delay line with four mechanisms:
  - per-source latched requests with configurable hold-off;
  - round-robin arbitration;
  - tracking of the tx engine's busy (eth_txen);
  - enforced inter-frame gap.

Parameters:
- NUM_SOURCES, 2, number of request sources (1..8).
- HOLDOFF_CYCLES, 100, cycles from a request pulse until that source becomes eligible; 0 means eligible on the next cycle.
- IFG_CYCLES, 48, idle cycles forced after tx busy falls (96 bit times at 2 bits/clk).
- START_TIMEOUT, 64, max cycles from launch to tx busy rising before abandoning.

Ports:
- clk_in  input  1  eth reference clock (50 MHz).
- rst_in  input  1  asynchronous, active-high reset.
- req_in  input  NUM_SOURCES  per-source request; a rising level or pulse is sampled every cycle while high.
- tx_busy_in  input  1  eth_txen from the tx engine.
- transmit_out  output  1  one-cycle launch pulse to eth_tx transmit.
- sel_out  output  $clog2(NUM_SOURCES) (min 1)  index of the granted source, held from launch until the next launch.
- grant_out  output  NUM_SOURCES  one-hot, one cycle, coincident with transmit_out.
- pending_out  output  NUM_SOURCES  per-source pending flag (holding off or eligible).
- drop_count_out  output  16  saturating count of requests lost because their source was already pending.
- err_timeout_out  output  1  sticky; set when START_TIMEOUT expires.

Behaviour:
- Reset values (asynchronous, immediate): all outputs 0, FSM IDLE, round-robin pointer 0, all hold-off counters 0.
- Per-source slot, req_in[i] high:
  - Slot not pending: pending[i] <= 1 and holdoff[i] <= HOLDOFF_CYCLES.
  - Slot already pending: drop, no state change.
- Drop counting: drop_count_out increases by the number of sources dropping in that cycle; saturates at 16'hFFFF, no wrap.
- Request held high: re-counts as a drop on every cycle the slot stays pending, so sources must pulse.
- Hold-off: holdoff[i] decrements each cycle while nonzero; source is eligible when pending[i]=1 and holdoff[i]=0.
- FSM states:
  - IDLE: if any source is eligible, select one by round-robin (search starts at pointer, wraps modulo NUM_SOURCES); go to LAUNCH.
  - LAUNCH (1 cycle): transmit_out=1, grant_out[k]=1, sel_out=k, pending[k] cleared, pointer <= (k+1) mod NUM_SOURCES, timeout counter loaded; go to WAIT_START.
  - WAIT_START: tx_busy_in=1 -> BUSY. Otherwise the counter decrements; on reaching 0, set err_timeout_out and go to GAP.
  - BUSY: on tx_busy_in=0, load gap counter with IFG_CYCLES and go to GAP.
  - GAP: count down; at 0 go to IDLE. No launch is possible while in GAP.
- Latency: eligible source in IDLE -> transmit_out on the next cycle. Minimum launch-to-launch spacing is 1 (LAUNCH) + 1 (WAIT_START) + busy length + IFG_CYCLES + 1 (IDLE).
- Simultaneous req_in[k] with LAUNCH clearing pending[k]: set wins. The source is re-pended with a fresh hold-off and this is not counted as a drop.
- tx_busy_in high while in IDLE (foreign activity): no launch until it drops; then a full GAP is applied before the next launch.
- NUM_SOURCES=1: pointer fixed at 0 and sel_out width is 1.
- Reset mid-frame: FSM returns to IDLE and pending requests are discarded. The tx engine is reset by the same rst_in.

Optional Feature:
- ETH_TX_SCHED_FIXED_PRIO_EN defined: round-robin is replaced by fixed priority (lowest index wins) and the pointer is not implemented.
- Undefined: round-robin exactly as above.

Test Plan:
- HOLDOFF=4, single req_in[0] pulse at cycle 10 -> transmit_out and grant_out=2'b01 at cycle 16; sel_out=0.
- req_in=2'b11 simultaneous, model busy 20 cycles each -> grants in order 01, 10, 01 across repeated pulses. Second launch exactly 20+IFG_CYCLES+3 cycles after the first. With ETH_TX_SCHED_FIXED_PRIO_EN the order is 01, 01.
- req_in[1] pulsed 3 times while pending -> drop_count_out=3. Force the count to 16'hFFFE, then 3 more drops -> 16'hFFFF.
- tx_busy_in never rises after launch -> err_timeout_out=1 at launch+1+START_TIMEOUT cycles, FSM passes through GAP, next launch proceeds.
- req_in[0] asserted in the same cycle as its LAUNCH -> pending_out[0] stays 1, no drop counted, second grant after hold-off + gap.
- rst_in asserted asynchronously in BUSY with both pending -> all outputs 0 immediately, no transmit_out after release until a new request.
